uart_rx: RTL and testbench

- 8N1 UART receiver; the downstream consumer of the uart_tx serial line. Sits next to uart_tx inside uart_loop, fed from the board RX pin or looped from o_uart_tx.
- Oversamples the line with the system clock and samples each bit at its mid-point.
- Delivers each received byte with a one-cycle valid strobe, or flags a framing error.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, data width, and the
// baud divider calculation used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Clocks per bit, truncating.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage flip-flop synchronizer for a single asynchronous bit, with a
// configurable reset value so an idle-high line does not look active after reset.
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= {STAGES{RST_VAL}};
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and valid / framing-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_sync;
    logic prev_reg;
    logic fall;

    uart_sync #(
        .STAGES (2),
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (i_uart_rx),
        .q  (rx_sync)
    );

    uart_rx_state_t       state_reg,      state_next;
    logic [CNT_W-1:0]     cnt_reg,        cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg,    bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,      shift_next;
    logic [DATA_BITS-1:0] data_reg,       data_next;
    logic                 valid_reg,      valid_next;
    logic                 frame_err_reg,  frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_reg, parity_bit_next;
    logic                 parity_err_reg, parity_err_next;
`endif

    assign fall = prev_reg & ~rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg       <= 1'b1;
            state_reg      <= WAIT_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            prev_reg       <= rx_sync;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        data_next       = data_reg;
        valid_next      = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            // A line held low through reset or a break must return high first.
            WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                cnt_next = '0;
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next        = '0;
                    parity_bit_next = rx_sync;
                    state_next      = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`endif
            // Leaving at mid-stop-bit lets an immediately following start edge be caught.
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if ((^shift_reg) != parity_bit_reg) begin
                            parity_err_next = 1'b1;
                        end else begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end
`else
                        data_next  = shift_reg;
                        valid_next = 1'b1;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = WAIT_IDLE;
            end
        endcase
    end

    assign o_data       = data_reg;
    assign o_valid      = valid_reg;
    assign o_frame_err  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_reg;
`endif
    assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of whole frames plus hand-written
// sequences for back-to-back frames, glitches, breaks and mid-frame reset.
module tb_uart_rx;

    localparam int BD         = 50_000_000 / 115200;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LATENCY    = 2 + BD / 2 + (FRAME_BITS - 1) * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx #(
        .CLK_FREQ(50_000_000),
        .BAUD    (115200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_uart_rx   (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy      (o_busy)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    logic [7:0]  vdata[$];
    int unsigned vcyc[$];
    int          ferr_cnt = 0;
    int          perr_cnt = 0;
    int          both_cnt = 0;
    always @(negedge clk) begin
        if (o_valid) begin
            vdata.push_back(o_data);
            vcyc.push_back(cyc);
        end
        if (o_frame_err) ferr_cnt++;
        if (o_valid && o_frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) perr_cnt++;
        if (o_parity_err && (o_valid || o_frame_err)) both_cnt++;
`endif
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Precondition: called #1 after a posedge. Returns #1 after the posedge that
    // ends the stop bit, leaving the line at the stop value.
    int unsigned fall_cyc;
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        rx = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(posedge clk);
            #1 rx = d[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (BD) @(posedge clk);
        #1 rx = (^d) ^ par_flip;
`endif
        repeat (BD) @(posedge clk);
        #1 rx = stop;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_flip;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int   n_vecs;

    initial begin
        int v0, f0, p0;
        vecs[0] = '{8'h3D, 1'b1, 1'b0, 1, 0, 0, 8'h3D};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 0, 1, 0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 1, 0, 0, 8'h81};
        vecs[5] = '{8'h3D, 1'b1, 1'b1, 0, 0, 1, 8'h81};
`ifdef UART_RX_PARITY_EN
        n_vecs = 6;
`else
        n_vecs = 5;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", o_data, 0);
        check("reset_valid", o_valid, 0);
        check("reset_ferr", o_frame_err, 0);
        check("reset_busy", o_busy, 1);
        rst = 1'b0;
        idle(10);
        check("idle_busy", o_busy, 0);

        // Table-driven frames
        for (int i = 0; i < n_vecs; i++) begin
            v0 = vdata.size(); f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
            idle(50);
            $display("vec %0d: sent 0x%02h stop=%0b flip=%0b -> o_data=0x%02h", i,
                     vecs[i].data, vecs[i].stop, vecs[i].par_flip, o_data);
            check($sformatf("vec%0d_valid_cnt", i), vdata.size() - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_cnt", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr_cnt", i), perr_cnt - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), o_busy, 0);
            if (vecs[i].exp_valid == 1 && vdata.size() == v0 + 1)
                check_range($sformatf("vec%0d_latency", i), vcyc[v0] - fall_cyc,
                            LATENCY, LATENCY + 2);
        end

        // Back-to-back 0xA5, 0x5A with no idle gap
        v0 = vdata.size();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(50);
        $display("b2b: %0d strobes", vdata.size() - v0);
        check("b2b_count", vdata.size() - v0, 2);
        if (vdata.size() >= v0 + 2) begin
            check("b2b_first", vdata[v0], 8'hA5);
            check("b2b_second", vdata[v0+1], 8'h5A);
            check_range("b2b_spacing", vcyc[v0+1] - vcyc[v0], FRAME_BITS * BD, FRAME_BITS * BD + 2);
        end

        // 100-cycle low glitch, then 0x01
        v0 = vdata.size(); f0 = ferr_cnt;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1 rx = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("glitch_busy_mid", o_busy, 1);
        idle(300);
        $display("glitch: busy=%0b", o_busy);
        check("glitch_busy_after", o_busy, 0);
        check("glitch_strobes", (vdata.size() - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(50);
        $display("after glitch: o_data=0x%02h", o_data);
        check("glitch_next_data", o_data, 8'h01);
        check("glitch_next_cnt", vdata.size() - v0, 1);

        // Framing error followed by a long break, then 0x81
        v0 = vdata.size(); f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (10000) @(posedge clk);
        #1;
        $display("break: ferr=%0d valid=%0d", ferr_cnt - f0, vdata.size() - v0);
        check("break_ferr_cnt", ferr_cnt - f0, 1);
        check("break_valid_cnt", vdata.size() - v0, 0);
        check("break_data_kept", o_data, 8'h01);
        check("break_busy", o_busy, 1);
        idle(50);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(50);
        $display("after break: o_data=0x%02h", o_data);
        check("break_next_data", o_data, 8'h81);
        check("break_next_cnt", vdata.size() - v0, 1);

        // Reset during data bit 4 of 0xFF, then 0xC3
        v0 = vdata.size(); f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (5 * BD + 200) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1;
                check("midrst_data", o_data, 0);
                check("midrst_busy", o_busy, 1);
                check("midrst_valid", o_valid, 0);
                rst = 1'b0;
            end
        join
        idle(50);
        $display("mid-frame reset: strobes=%0d", (vdata.size() - v0) + (ferr_cnt - f0));
        check("midrst_strobes", (vdata.size() - v0) + (ferr_cnt - f0), 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(50);
        $display("after reset: o_data=0x%02h", o_data);
        check("midrst_next_data", o_data, 8'hC3);
        check("midrst_next_cnt", vdata.size() - v0, 1);

        check("no_overlapping_strobes", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
